// File: rtl/switch_debouncer.sv
// switch_debouncer
// Input conditioner for the board's slide switches and pushbuttons. Every raw
// pin is brought into the clk domain through a two-flop synchroniser. A
// per-channel stability counter then accepts a new level only after it has
// been held long enough. The block provides clean levels, one-cycle rise and
// fall pulses, and sticky event flags that can be cleared by mask.
module switch_debouncer #(
  parameter int WIDTH           = 12,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] event_flags,
  input  logic             clear_req,
  input  logic [WIDTH-1:0] clear_mask,
  output logic             any_event
);

  // The last count value. On the next mismatching edge the new level is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Synchroniser stages. These are kept as plain flop-to-flop paths.
  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;

  // Debounced state and the registered outputs.
  logic [WIDTH-1:0] stable_reg;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] rise_reg;
  logic [WIDTH-1:0] rise_next;
  logic [WIDTH-1:0] fall_reg;
  logic [WIDTH-1:0] fall_next;
  logic [WIDTH-1:0] flags_reg;
  logic [WIDTH-1:0] flags_next;

  // A bit is high on the edge where its channel commits a new level.
  logic [WIDTH-1:0] accept_vec;

  // Two-stage synchroniser for the asynchronous pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= raw_in;
      s2_reg <= s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             level_next;
      logic             accept;

      // Stability counter. Any edge where the synchronised input matches the
      // accepted level aborts a pending change. A full run of mismatches
      // commits the new level, and the counter restarts from zero.
      always_comb begin
        cnt_next   = '0;
        level_next = stable_reg[gi];
        accept     = 1'b0;
        if (s2_reg[gi] != stable_reg[gi]) begin
          if (cnt_reg == CNT_MAX) begin
            level_next = s2_reg[gi];
            accept     = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end

      // Per-channel counter register. A reset discards any partial count.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign accept_vec[gi]  = accept;
      assign stable_next[gi] = level_next;
    end
  endgenerate

  // Pulse and flag next-state logic. When a set and a clear hit the same bit
  // on one edge, the set wins, so an event is never lost.
  always_comb begin
    rise_next  = accept_vec & stable_next;
    fall_next  = accept_vec & ~stable_next;
    flags_next = (flags_reg & ~({WIDTH{clear_req}} & clear_mask)) | accept_vec;
  end

  // Registered debounced level, edge pulses and sticky event flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_reg <= '0;
      rise_reg   <= '0;
      fall_reg   <= '0;
      flags_reg  <= '0;
    end else begin
      stable_reg <= stable_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      flags_reg  <= flags_next;
    end
  end

  assign stable_out  = stable_reg;
  assign rise_pulse  = rise_reg;
  assign fall_pulse  = fall_reg;
  assign event_flags = flags_reg;
  assign any_event   = |flags_reg;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer
// Directed scenarios followed by a randomised phase. Every edge is compared
// against a behavioural model. The model treats each channel as a pin that is
// seen two edges late. A new level is taken once the delayed pin has disagreed
// with the accepted level for D edges in a row.
module tb_switch_debouncer;

  localparam int W = 12;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] stable_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic [W-1:0] event_flags;
  logic         clear_req = 1'b0;
  logic [W-1:0] clear_mask = '0;
  logic         any_event;

  int n_checks = 0;
  int n_err    = 0;
  int edge_no  = 0;

  // Behavioural model state.
  logic [W-1:0] m_seen [2];  // pin as seen one and two edges later
  logic [W-1:0] m_stable, m_rise, m_fall, m_flags;
  int           m_run [W];   // consecutive edges of disagreement

  switch_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .stable_out(stable_out),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .event_flags(event_flags),
    .clear_req(clear_req), .clear_mask(clear_mask), .any_event(any_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  task automatic model_reset();
    m_seen[0] = '0; m_seen[1] = '0;
    m_stable = '0; m_rise = '0; m_fall = '0; m_flags = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [W-1:0] acc;
    acc = '0;
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < W; i++) begin
        if (m_seen[1][i] != m_stable[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            acc[i]   = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_stable  = m_stable ^ acc;
      m_rise    = acc & m_stable;
      m_fall    = acc & ~m_stable;
      m_flags   = (m_flags & ~(clear_req ? clear_mask : '0)) | acc;
      m_seen[1] = m_seen[0];
      m_seen[0] = raw_in;
      if (acc != '0)
        $display("edge %0d accept=%h stable=%h flags=%h", edge_no, acc, m_stable, m_flags);
    end
  endtask

  task automatic check_all();
    chk("stable_out", 32'(stable_out), 32'(m_stable));
    chk("rise_pulse", 32'(rise_pulse), 32'(m_rise));
    chk("fall_pulse", 32'(fall_pulse), 32'(m_fall));
    chk("event_flags", 32'(event_flags), 32'(m_flags));
    chk("any_event", 32'(any_event), 32'(m_flags != '0));
  endtask

  // One clock edge: update the model at the edge, then sample the outputs 1 ns later.
  task automatic step();
    @(posedge clk);
    edge_no++;
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int rise5_cnt, fall5_cnt, rise5_at;
    model_reset();

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    repeat (10) step();
    chk("t1_stable", 32'(stable_out), 32'h0);
    chk("t1_any", 32'(any_event), 32'h0);
    $display("t1 reset/idle done");

    // 2: single rise on bit 0, taken on edge 6
    raw_in = 12'h001;
    repeat (5) step();
    chk("t2_stable_pre", 32'(stable_out), 32'h000);
    step();
    chk("t2_stable", 32'(stable_out), 32'h001);
    chk("t2_rise", 32'(rise_pulse), 32'h001);
    chk("t2_flags", 32'(event_flags), 32'h001);
    chk("t2_any", 32'(any_event), 32'h1);
    step();
    chk("t2_rise_gone", 32'(rise_pulse), 32'h000);
    $display("t2 rise bit0 done");

    // 3: three-edge glitch on bit 3 is rejected
    raw_in[3] = 1'b1;
    repeat (3) step();
    raw_in[3] = 1'b0;
    repeat (10) step();
    chk("t3_stable", 32'(stable_out), 32'h001);
    chk("t3_flags", 32'(event_flags), 32'h001);
    $display("t3 glitch rejected");

    // 4: bit 5 bounces every 2 edges, then settles high
    rise5_cnt = 0; fall5_cnt = 0; rise5_at = -1;
    for (int seg = 0; seg < 10; seg++) begin
      raw_in[5] = (seg % 2 == 0);
      repeat (2) begin
        step();
        if (rise_pulse[5]) rise5_cnt++;
        if (fall_pulse[5]) fall5_cnt++;
      end
    end
    raw_in[5] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (rise_pulse[5]) begin rise5_cnt++; rise5_at = k; end
      if (fall_pulse[5]) fall5_cnt++;
    end
    chk("t4_rise_count", 32'(rise5_cnt), 32'd1);
    chk("t4_rise_edge", 32'(rise5_at), 32'd6);
    chk("t4_fall_count", 32'(fall5_cnt), 32'd0);
    $display("t4 bounce on bit5 done");

    // 5: a clear on the same edge as an accept keeps the new event
    clear_req = 1'b1; clear_mask = 12'hfff;
    step();
    clear_req = 1'b0; clear_mask = '0;
    chk("t5_cleared", 32'(event_flags), 32'h000);
    raw_in[0] = 1'b0;
    repeat (6) step();
    chk("t5_fall0", 32'(fall_pulse), 32'h001);
    raw_in[0] = 1'b1; raw_in[1] = 1'b1;
    repeat (6) step();
    chk("t5_dual_rise", 32'(rise_pulse), 32'h003);
    chk("t5_flags3", 32'(event_flags), 32'h003);
    raw_in[0] = 1'b0;
    repeat (5) step();
    clear_req = 1'b1; clear_mask = 12'h003;
    step();
    clear_req = 1'b0; clear_mask = '0;
    chk("t5_flags_setwins", 32'(event_flags), 32'h001);
    chk("t5_fall_pulse", 32'(fall_pulse), 32'h001);
    $display("t5 clear vs accept done");

    // 6: reset in mid-count on bit 7
    raw_in[7] = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_async_stable", 32'(stable_out), 32'h000);
    chk("t6_async_flags", 32'(event_flags), 32'h000);
    check_all();
    repeat (2) step();
    reset = 1'b0;
    repeat (5) step();
    chk("t6_rise_early", 32'(rise_pulse), 32'h000);
    step();
    chk("t6_rise", 32'(rise_pulse), 32'h0a2);
    step();
    chk("t6_rise_once", 32'(rise_pulse), 32'h000);
    $display("t6 reset mid-count done");

    // Random phase: slow random toggling with glitches and random clears
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(11) == 0) raw_in[i] = ~raw_in[i];
      clear_req  = ($urandom_range(4) == 0);
      clear_mask = W'($urandom);
      if (n == 200) begin
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
      end
      step();
      if (n == 200) reset = 1'b0;
    end
    $display("random phase done");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
